// File: rtl/video_pkg.sv
// Shared video-path types: 7.2 fixed-point frame rate, rate-mode enum, default
// 50/60 Hz decision thresholds, and the rate-detector FSM state encoding.
package video_pkg;

  localparam int FREQ_FRAC_BITS = 2;
  localparam int FREQ_W         = 9;

  typedef logic [FREQ_W-1:0] freq_q7_2_t;

  localparam int TH_UP_DEF = 228;
  localparam int TH_DN_DEF = 220;

  typedef enum logic {
    MODE_50,
    MODE_60
  } rate_mode_e;

  typedef enum logic [1:0] {
    WAIT_EDGE,
    MEASURE,
    DIVIDE,
    UPDATE
  } rd_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. A done pulse follows
// the final bit, and abort drops any division in flight.
module seq_divider #(
  parameter int W  = 32,
  parameter int QW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int BW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic [W:0]    shifted;
  logic [W-1:0]  diff;
  logic          ge;
  logic          busy;
  logic [BW-1:0] bits_left;

  // When ge holds, the true difference is below the divisor, so W bits suffice.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    ge      = shifted >= {1'b0, dvs_q};
    diff    = shifted[W-1:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      rem_q <= ge ? diff : shifted[W-1:0];
      quo_q <= {quo_q[W-2:0], ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_left <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        bits_left <= BW'(W);
      end else if (busy) begin
        bits_left <= bits_left - 1'b1;
        if (bits_left == BW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[QW-1:0];

endmodule

// File: rtl/pal_rate_detect.sv
// Measures the source vsync period, converts it to a 7.2 Hz rate, and makes a
// debounced, hysteretic 50/60 Hz decision for the upscaler path select.
module pal_rate_detect
  import video_pkg::*;
#(
  parameter int CLK_HZ        = 297_000_000,
  parameter int MIN_HZ        = 20,
  parameter int MAX_HZ        = 100,
  parameter int STABLE_FRAMES = 4,
  parameter int TH_UP         = TH_UP_DEF,
  parameter int TH_DN         = TH_DN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_vsync,
  output freq_q7_2_t o_freq,
  output logic       o_valid,
  output logic       o_update,
  output logic       o_locked,
  output logic       o_mode_50,
  output logic       o_mode_60,
  output logic       o_no_signal
);

  localparam int unsigned MAX_CNT  = CLK_HZ / MIN_HZ;
  localparam int unsigned MIN_PER  = CLK_HZ / MAX_HZ;
  localparam int          CW       = $clog2(MAX_CNT) + 1;
  localparam longint      DIVIDEND = 4 * longint'(CLK_HZ);
  localparam int          DIV_W    = $clog2(DIVIDEND + 1);
  localparam int          SW       = $clog2(STABLE_FRAMES + 1);

  localparam logic [CW-1:0] MAX_CNT_V = CW'(MAX_CNT);
  localparam logic [CW-1:0] MIN_PER_V = CW'(MIN_PER);
  localparam logic [SW-1:0] LOCK_V    = SW'(STABLE_FRAMES);
  localparam freq_q7_2_t    TH_UP_V   = FREQ_W'(TH_UP);
  localparam freq_q7_2_t    TH_DN_V   = FREQ_W'(TH_DN);
  localparam freq_q7_2_t    TOL_V     = FREQ_W'(1 << FREQ_FRAC_BITS);

  function automatic logic [SW-1:0] stable_inc(input logic [SW-1:0] s);
    return (s == LOCK_V) ? s : s + 1'b1;
  endfunction

  function automatic logic near_freq(input freq_q7_2_t a, input freq_q7_2_t b);
    freq_q7_2_t d;
    d = (a >= b) ? a - b : b - a;
    return d <= TOL_V;
  endfunction

  logic            vsync_d1;
  logic            rise;
  logic [CW-1:0]   cnt;
  logic            sat;
  logic            timeout;
  logic            period_ok;
  rd_state_e       state;
  rd_state_e       state_nx;
  logic [SW-1:0]   stable;
  rate_mode_e      mode;
  logic            div_start;
  logic            div_abort;
  logic            div_done;
  freq_q7_2_t      div_quo;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;

  assign sat          = (cnt == MAX_CNT_V);
  assign timeout      = sat && !rise;
  assign period_ok    = (cnt >= MIN_PER_V);
  assign div_dividend = DIV_W'(DIVIDEND);
  assign div_divisor  = DIV_W'(cnt);

  seq_divider #(
    .W  (DIV_W),
    .QW (FREQ_W)
  ) u_div (
    .clk      (clk),
    .rst      (reset),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_EDGE;
    else       state <= state_nx;
  end

  // A saturated period counter overrides every state: the source is gone.
  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = WAIT_EDGE;
    end else begin
      case (state)
        WAIT_EDGE: if (rise) state_nx = MEASURE;
        MEASURE:   if (rise && period_ok) state_nx = DIVIDE;
        DIVIDE: begin
          if (rise)          state_nx = MEASURE;
          else if (div_done) state_nx = UPDATE;
        end
        UPDATE:    state_nx = MEASURE;
        default:   state_nx = WAIT_EDGE;
      endcase
    end
  end

  always_comb begin
    div_start = 1'b0;
    div_abort = timeout;
    case (state)
      MEASURE: div_start = rise && period_ok;
      DIVIDE:  if (rise) div_abort = 1'b1;
      default: ;
    endcase
    o_locked  = (stable == LOCK_V);
    o_mode_50 = o_locked && (mode == MODE_50);
    o_mode_60 = o_locked && (mode == MODE_60);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d1    <= 1'b0;
      rise        <= 1'b0;
      cnt         <= '0;
      o_freq      <= '0;
      o_valid     <= 1'b0;
      o_update    <= 1'b0;
      o_no_signal <= 1'b1;
      stable      <= '0;
      mode        <= MODE_50;
    end else begin
      vsync_d1 <= i_vsync;
      rise     <= i_vsync & ~vsync_d1;
      o_update <= 1'b0;
      if (rise)      cnt <= CW'(1);
      else if (!sat) cnt <= cnt + 1'b1;
      if (timeout) begin
        o_no_signal <= 1'b1;
        o_valid     <= 1'b0;
        stable      <= '0;
      end else begin
        case (state)
          WAIT_EDGE: if (rise) o_no_signal <= 1'b0;
          MEASURE:   if (rise && !period_ok) stable <= '0;
          DIVIDE:    if (rise) stable <= '0;
          UPDATE: begin
            o_freq   <= div_quo;
            o_update <= 1'b1;
            o_valid  <= 1'b1;
            stable   <= near_freq(div_quo, o_freq) ? stable_inc(stable) : SW'(1);
            // Hysteresis: quotients inside (TH_DN, TH_UP) keep the current mode.
            if (mode == MODE_50 && div_quo >= TH_UP_V)      mode <= MODE_60;
            else if (mode == MODE_60 && div_quo <= TH_DN_V) mode <= MODE_50;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pal_rate_detect.sv
// Bench for pal_rate_detect: directed frame sequences plus randomized periods,
// checked against a frame-level model of rate, lock and mode decisions.
module tb_pal_rate_detect;

  localparam int CLK_HZ  = 100_000;
  localparam int MIN_HZ  = 20;
  localparam int MAX_HZ  = 100;
  localparam int STABLE  = 4;
  localparam int TH_UP   = 228;
  localparam int TH_DN   = 220;
  localparam int MAX_GAP = CLK_HZ / MIN_HZ;
  localparam int MIN_PER = CLK_HZ / MAX_HZ;
  localparam int DIV_W   = $clog2(4 * CLK_HZ + 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       i_vsync;
  logic [8:0] o_freq;
  logic       o_valid;
  logic       o_update;
  logic       o_locked;
  logic       o_mode_50;
  logic       o_mode_60;
  logic       o_no_signal;

  always #5 clk = ~clk;

  pal_rate_detect #(
    .CLK_HZ        (CLK_HZ),
    .MIN_HZ        (MIN_HZ),
    .MAX_HZ        (MAX_HZ),
    .STABLE_FRAMES (STABLE),
    .TH_UP         (TH_UP),
    .TH_DN         (TH_DN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_vsync     (i_vsync),
    .o_freq      (o_freq),
    .o_valid     (o_valid),
    .o_update    (o_update),
    .o_locked    (o_locked),
    .o_mode_50   (o_mode_50),
    .o_mode_60   (o_mode_60),
    .o_no_signal (o_no_signal)
  );

  int n_vec = 0;
  int n_err = 0;

  // Frame-level reference state
  bit m_wait;
  bit m_nosig;
  bit m_valid;
  bit m_mode60;
  int m_stable;
  int m_freq;
  int prev_gap;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait   = 1'b1;
    m_nosig  = 1'b1;
    m_valid  = 1'b0;
    m_mode60 = 1'b0;
    m_stable = 0;
    m_freq   = 0;
  endtask

  task automatic model_rise(output bit exp_upd);
    int q;
    int d;
    exp_upd = 1'b0;
    if (m_wait) begin
      m_wait  = 1'b0;
      m_nosig = 1'b0;
    end else if (prev_gap < MIN_PER) begin
      m_stable = 0;
    end else begin
      q       = (4 * CLK_HZ) / prev_gap;
      d       = (q > m_freq) ? q - m_freq : m_freq - q;
      exp_upd = 1'b1;
      if (d <= 4) m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
      else        m_stable = 1;
      if (!m_mode60 && q >= TH_UP)     m_mode60 = 1'b1;
      else if (m_mode60 && q <= TH_DN) m_mode60 = 1'b0;
      m_freq  = q;
      m_valid = 1'b1;
    end
  endtask

  task automatic check_flags(input string tag);
    bit lk;
    lk = (m_stable == STABLE);
    check_eq({tag, ".freq"},      int'(o_freq),      m_freq);
    check_eq({tag, ".valid"},     int'(o_valid),     int'(m_valid));
    check_eq({tag, ".locked"},    int'(o_locked),    int'(lk));
    check_eq({tag, ".mode_50"},   int'(o_mode_50),   int'(lk && !m_mode60));
    check_eq({tag, ".mode_60"},   int'(o_mode_60),   int'(lk && m_mode60));
    check_eq({tag, ".no_signal"}, int'(o_no_signal), int'(m_nosig));
  endtask

  // Rising vsync now; the next rise follows exactly gap cycles later.
  task automatic pulse(input int gap);
    bit exp_upd;
    int n_upd;
    int lat;
    int fr;
    n_upd = 0;
    lat   = -1;
    fr    = -1;
    model_rise(exp_upd);
    i_vsync = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      if (i == 8) i_vsync = 1'b0;
      if (o_update) begin
        n_upd++;
        lat = i;
        fr  = int'(o_freq);
      end
    end
    check_eq("update_count", n_upd, exp_upd ? 1 : 0);
    if (exp_upd && n_upd == 1) begin
      check_eq("update_freq", fr, m_freq);
      check_eq("update_latency_in_window", int'(lat >= DIV_W + 2 && lat <= DIV_W + 5), 1);
    end
    check_flags("frame");
    prev_gap = gap;
  endtask

  task automatic timeout_check();
    pulse(MAX_GAP - 10);
    repeat (20) @(negedge clk);
    m_wait   = 1'b1;
    m_nosig  = 1'b1;
    m_valid  = 1'b0;
    m_stable = 0;
    check_flags("timeout");
  endtask

  task automatic reset_mid_divide();
    int n_upd;
    n_upd = 0;
    i_vsync = 1'b1;
    repeat (7) @(negedge clk);
    reset   = 1'b1;
    i_vsync = 1'b0;
    @(negedge clk);
    model_reset();
    check_flags("rst_mid");
    check_eq("rst_mid.update", int'(o_update), 0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_update) n_upd++;
    end
    check_eq("rst_mid.no_commit", n_upd, 0);
  endtask

  initial begin
    reset    = 1'b1;
    i_vsync  = 1'b0;
    prev_gap = 0;
    repeat (3) @(negedge clk);
    model_reset();
    check_flags("reset");
    check_eq("reset.update", int'(o_update), 0);
    reset = 1'b0;
    @(negedge clk);

    // 50 Hz lock
    repeat (6) pulse(2000);
    // glitch 300 cycles after a valid edge, then relock
    pulse(300);
    pulse(1700);
    repeat (5) pulse(2000);
    // switch to 60 Hz
    repeat (5) pulse(1666);
    // in-band rate keeps 60, then 219 drops to 50
    repeat (5) pulse(1786);
    repeat (2) pulse(1820);
    // walk up through 223/227 to exactly TH_UP, then down through 224/221 to exactly TH_DN
    pulse(1786);
    pulse(1762);
    pulse(1754);
    pulse(1785);
    pulse(1809);
    pulse(1818);
    pulse(1500);
    // shortest accepted period versus one cycle shorter
    pulse(1000);
    pulse(999);
    pulse(1000);
    pulse(1000);
    // randomized periods with occasional glitches
    for (int k = 0; k < 5; k++) begin
      int g;
      if ($urandom_range(0, 3) == 0) g = int'($urandom_range(100, 900));
      else                           g = int'($urandom_range(MIN_PER, 1300));
      pulse(g);
    end
    pulse(1200);
    // source loss and recovery
    timeout_check();
    pulse(1500);
    // reset while the divider is running
    reset_mid_divide();
    repeat (2) pulse(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
